// File: rtl/nic_pkg.sv
// Shared constants for the single-entry network interface controller.
package nic_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 2;
  localparam int VC_BIT     = DATA_WIDTH - 1;

  // Memory-mapped slot addresses seen by the pipeline
  localparam logic [ADDR_WIDTH-1:0] NIC_IN_DATA  = 2'b00;
  localparam logic [ADDR_WIDTH-1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [ADDR_WIDTH-1:0] NIC_OUT_DATA = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] NIC_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_buffer.sv
// One-entry packet buffer. A load is accepted only while the buffer is
// empty; a load that arrives while full is silently dropped. A consume
// empties the buffer but leaves the data register untouched, so a later
// read of an empty buffer returns the stale contents.
module nic_buffer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_consume,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic [W-1:0] r_data;

  // Load has priority only when empty; the full-state consume clears the flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (i_load && !r_full) begin
        r_data <= i_data;
        r_full <= 1'b1;
      end else if (i_consume) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/nic.sv
// Network interface controller between the processor pipeline and a
// router port. Holds one incoming and one outgoing packet.
//
// Router handshake: an incoming transfer happens on a rising edge where
// net_si and net_ri are both high; an outgoing transfer happens on a rising
// edge where net_so is high. net_so already includes net_ro and the
// even/odd virtual-channel gate, so the router only samples net_so/net_do.
module nic
  import nic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_in_full;
  logic [DATA_WIDTH-1:0] w_in_data;
  logic                  w_out_full;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic                  w_in_load;
  logic                  w_in_consume;
  logic                  w_out_load;
  logic                  w_vc_match;
  logic                  w_send;

  assign w_rd = nicEn & ~nicEnWr;
  assign w_wr = nicEn & nicEnWr;

  // Incoming path: accept whenever the input slot is empty
  assign net_ri       = ~w_in_full;
  assign w_in_load    = net_si & net_ri;
  assign w_in_consume = w_rd & (addr == NIC_IN_DATA) & w_in_full;

  // Outgoing path: only a write to the out-data slot loads; the buffer
  // drops it if still full, including the cycle the send completes
  assign w_out_load = w_wr & (addr == NIC_OUT_DATA);
  assign w_vc_match = (w_out_data[VC_BIT] == net_polarity);
  assign w_send     = w_out_full & net_ro & w_vc_match;
  assign net_so     = w_send;
  assign net_do     = w_out_data;

  nic_buffer #(.W(DATA_WIDTH)) u_in_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_in_load),
    .i_data    (net_di),
    .i_consume (w_in_consume),
    .o_full    (w_in_full),
    .o_data    (w_in_data)
  );

  nic_buffer #(.W(DATA_WIDTH)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_out_load),
    .i_data    (d_in),
    .i_consume (w_send),
    .o_full    (w_out_full),
    .o_data    (w_out_data)
  );

  // Processor read mux; zero whenever no read is in progress
  always_comb begin
    d_out = '0;
    if (w_rd) begin
      case (addr)
        NIC_IN_DATA:  d_out = w_in_data;
        NIC_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, w_in_full};
        NIC_OUT_DATA: d_out = '0;
        NIC_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, w_out_full};
        default:      d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nic.sv
// Directed bench for nic with a scoreboard: expected read data and
// expected outgoing packets are queued by the stimulus, and a monitor on
// the falling edge pops and compares whenever the DUT presents them.
module tb_nic;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic [1:0]   addr;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic         nicEn;
  logic         nicEnWr;
  logic         net_si;
  logic         net_ri;
  logic [W-1:0] net_di;
  logic         net_so;
  logic         net_ro;
  logic [W-1:0] net_do;
  logic         net_polarity;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_tx_q[$];
  int total;
  int bad;

  nic dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicEnWr      (nicEnWr),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (nicEn && !nicEnWr) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
      else chk("rd_data", d_out, exp_q.pop_front());
    end else if (!nicEn) begin
      chk("idle_dout", d_out, '0);
    end
    if (net_so) begin
      if (exp_tx_q.size() == 0) chk("tx_unexpected", 64'd1, 64'd0);
      else chk("tx_data", net_do, exp_tx_q.pop_front());
      chk("tx_vc_gate", {63'd0, net_do[W-1]}, {63'd0, net_polarity});
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [W-1:0] exp);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
    exp_q.push_back(exp);
    cyc();
    nicEn = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    nicEn = 1'b1; nicEnWr = 1'b1; addr = a; d_in = d;
    cyc();
    nicEn = 1'b0; nicEnWr = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicEnWr = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;

    // Reset state
    #3;
    chk("rst_ri", {63'd0, net_ri}, 64'd1);
    chk("rst_so", {63'd0, net_so}, 64'd0);
    chk("rst_do", net_do, '0);
    cyc();
    rst = 1'b0;
    rd(2'b01, 64'd0);
    rd(2'b11, 64'd0);

    // Receive path
    net_si = 1'b1; net_di = 64'h8000_0000_0000_00AA;
    cyc();
    net_si = 1'b0;
    chk("rx_ri_low", {63'd0, net_ri}, 64'd0);
    rd(2'b01, 64'd1);
    rd(2'b00, 64'h8000_0000_0000_00AA);
    chk("rx_ri_free", {63'd0, net_ri}, 64'd1);
    rd(2'b01, 64'd0);
    rd(2'b00, 64'h8000_0000_0000_00AA);

    // Send with polarity gate
    net_ro = 1'b1; net_polarity = 1'b0;
    exp_tx_q.push_back(64'h8000_0000_0000_1234);
    wr(2'b10, 64'h8000_0000_0000_1234);
    chk("tx_do_visible", net_do, 64'h8000_0000_0000_1234);
    chk("tx_gate_pol0", {63'd0, net_so}, 64'd0);
    rd(2'b11, 64'd1);
    net_polarity = 1'b1; #1;
    chk("tx_gate_pol1", {63'd0, net_so}, 64'd1);
    cyc();
    chk("tx_done_so", {63'd0, net_so}, 64'd0);
    rd(2'b11, 64'd0);

    // Full output: second write dropped
    net_ro = 1'b0;
    exp_tx_q.push_back(64'h0000_0000_0000_0001);
    wr(2'b10, 64'h0000_0000_0000_0001);
    wr(2'b10, 64'h0000_0000_0000_0002);
    chk("full_do_kept", net_do, 64'h0000_0000_0000_0001);
    rd(2'b11, 64'd1);
    net_ro = 1'b1; net_polarity = 1'b1; #1;
    chk("full_gate_mis", {63'd0, net_so}, 64'd0);
    net_polarity = 1'b0; #1;
    chk("full_gate_ok", {63'd0, net_so}, 64'd1);
    cyc();
    chk("full_sent_so", {63'd0, net_so}, 64'd0);

    // Send completion coinciding with a write: write dropped
    net_ro = 1'b0;
    exp_tx_q.push_back(64'h0000_0000_0000_0003);
    wr(2'b10, 64'h0000_0000_0000_0003);
    net_ro = 1'b1;
    wr(2'b10, 64'h0000_0000_0000_0004);
    chk("coinc_so", {63'd0, net_so}, 64'd0);
    chk("coinc_do", net_do, 64'h0000_0000_0000_0003);
    rd(2'b11, 64'd0);

    // Back-pressure
    net_si = 1'b1; net_di = 64'h11;
    cyc();
    net_di = 64'h22;
    cyc();
    cyc();
    chk("bp_ri_low", {63'd0, net_ri}, 64'd0);
    rd(2'b01, 64'd1);
    rd(2'b00, 64'h11);
    chk("bp_ri_free", {63'd0, net_ri}, 64'd1);
    cyc();
    net_si = 1'b0;
    chk("bp_ri_recap", {63'd0, net_ri}, 64'd0);
    rd(2'b00, 64'h22);

    // Decode: ignored writes, read of out-data, idle with any addr
    wr(2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(2'b01, 64'd0);
    rd(2'b11, 64'd0);
    rd(2'b00, 64'h22);
    rd(2'b10, 64'd0);
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      cyc();
    end

    // Reset mid-operation with both buffers full
    net_ro = 1'b0;
    wr(2'b10, 64'h55);
    net_si = 1'b1; net_di = 64'h66;
    cyc();
    net_si = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ri", {63'd0, net_ri}, 64'd1);
    chk("mid_rst_so", {63'd0, net_so}, 64'd0);
    chk("mid_rst_do", net_do, '0);
    rd(2'b01, 64'd0);
    rd(2'b11, 64'd0);
    rst = 1'b0;
    rd(2'b00, 64'd0);
    net_ro = 1'b1; net_polarity = 1'b0; #1;
    chk("post_rst_so0", {63'd0, net_so}, 64'd0);
    net_polarity = 1'b1; #1;
    chk("post_rst_so1", {63'd0, net_so}, 64'd0);
    cyc();
    cyc();

    // Report
    chk("rd_q_empty", 64'(exp_q.size()), 64'd0);
    chk("tx_q_empty", 64'(exp_tx_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nic.md
# nic

Single-entry network interface controller between the 4-stage processor pipeline and its router port. It exposes four memory-mapped slots to the pipeline: input data, input status, output data and output status. Processor accesses use `nicEn`/`nicEnWr` and the low two bits of the data-memory address. The router side uses a send/ready handshake with an even/odd polarity (virtual-channel) gate on outgoing packets.

## Interface
- `DATA_WIDTH`, 64, packet and processor data width; bit `DATA_WIDTH-1` is the VC bit.
- `ADDR_WIDTH`, 2, processor-side slot address width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `addr` input 2: slot select; 00 in-data, 01 in-status, 10 out-data, 11 out-status.
- `d_in` input 64: processor write data.
- `d_out` output 64: processor read data (combinational).
- `nicEn` input 1: processor access strobe.
- `nicEnWr` input 1: write when 1, read when 0; qualified by `nicEn`.
- `net_si` input 1: router presents a packet.
- `net_ri` output 1: NIC can accept an incoming packet.
- `net_di` input 64: incoming packet.
- `net_so` output 1: NIC presents an outgoing packet.
- `net_ro` input 1: router can accept an outgoing packet.
- `net_do` output 64: outgoing packet.
- `net_polarity` input 1: router's current cycle polarity.

## Operation
- **State.** `in_buf`, `in_full`, `out_buf`, `out_full`.
- **Incoming path.**
  - `net_ri = ~in_full`.
  - A transfer occurs at an edge with `net_si & net_ri`: `in_buf <= net_di`, `in_full <= 1`.
- **Processor read, `nicEn & ~nicEnWr`.**
  - addr 00: `d_out = in_buf`. If `in_full`, `in_full <= 0` at the edge; if empty, returns stale `in_buf` with no state change.
  - addr 01: `d_out = {63'b0, in_full}`.
  - addr 10: `d_out = 0`.
  - addr 11: `d_out = {63'b0, out_full}`.
- **No access.** With `nicEn = 0`, `d_out = 0`.
- **Processor write, `nicEn & nicEnWr`.**
  - addr 10 with `out_full = 0`: `out_buf <= d_in`, `out_full <= 1`.
  - addr 10 with `out_full = 1`: write dropped. Software must poll addr 11 first.
  - Writes to addr 00, 01 or 11 are ignored.
- **Outgoing path.**
  - `net_so = out_full & net_ro & (out_buf[63] == net_polarity)`.
  - `net_do = out_buf` always.
  - At an edge with `net_so`, `out_full <= 0`.
- **Simultaneous events.**
  - Send completion plus processor write in the same cycle: write dropped, because status was full.
  - Router delivery plus processor read of 00 cannot coincide (`net_ri = 0` while full).
  - Reading 01 or 11 never changes state.

## Timing
- Reset (async, immediate): `in_full = 0`, `out_full = 0`, `in_buf = 0`, `out_buf = 0`.
- Outputs during reset: `net_ri = 1`, `net_so = 0`, `net_do = 0`, `d_out = 0` while `nicEn = 0`.
- Reset mid-operation discards both buffers with no partial transfer. Any packet presented in the reset cycle is lost.
- Read latency: `d_out` is valid in the same cycle as `nicEn`/`addr`; the pipeline registers it at the stage-3 boundary.
- Write latency: the packet is visible on `net_do` the cycle after the write edge. `net_so` asserts that cycle at the earliest, when polarity matches and `net_ro = 1`.
- Receive latency: a packet accepted at edge N reads as status 1 from cycle N+1. Slot 00 becomes free (`net_ri = 1`) the cycle after the consuming read edge.
- Throughput: one packet per direction per two cycles at most. Polarity halves the outgoing rate in steady state.

## Structure
- Package `nic_pkg`:
  - slot constants `NIC_IN_DATA = 2'b00`, `NIC_IN_STAT = 2'b01`, `NIC_OUT_DATA = 2'b10`, `NIC_OUT_STAT = 2'b11`;
  - `DATA_WIDTH`;
  - `VC_BIT = DATA_WIDTH-1`.
- Sub-module `nic_buffer`:
  - one-entry register with async-reset full flag, load strobe, consume strobe and dropped-load suppression;
  - instantiated twice (input and output).
- Top-level `nic` holds address decode, the `d_out` mux and the polarity gate.

## Test plan
- **Reset.** Assert `rst` mid-transfer with both buffers full -> `net_ri = 1`, `net_so = 0`; reads of 01 and 11 return 0 immediately.
- **Receive path.** Drive `net_si = 1`, `net_di = 64'h8000_0000_0000_00AA` -> `net_ri = 0` next cycle and status 01 = 1. Read 00 returns `...00AA`; `net_ri = 1` the following cycle.
- **Send with polarity gate.** Write `64'h8000_0000_0000_1234` to 10 with `net_ro = 1`, polarity toggling from 0 -> `net_so` is high only in cycles with polarity 1. Then status 11 = 0.
- **Full output.** Hold `net_ro = 0` and write `...0001` then `...0002` to 10 -> `net_do` stays `...0001`; the second write is dropped.
- **Back-pressure.** Hold `net_si = 1` with `in_full = 1` -> `in_buf` unchanged until read. The new packet is captured on the edge after the read.
- **Decode.** Writes to 00, 01 and 11 change nothing. Read of 10 = 0. `nicEn = 0` gives `d_out = 0` regardless of `addr`.
